perceptron_output_layer_seq: RTL and testbench



---
 rtl/perceptron_pkg.sv | 20 ++
 rtl/perceptron_output_layer_seq_if.sv | 25 ++
 rtl/perceptron_weight_rf.sv | 34 +++
 rtl/perceptron_output_layer_seq.sv | 121 ++++++++++++
 tb/tb_perceptron_output_layer_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/perceptron_pkg.sv
// Shared constants, reset values and FSM state type for the output-layer perceptron.
package perceptron_pkg;

  localparam int N_IN     = 8;
  localparam int W_W      = 8;
  localparam int ACC_W    = 11;
  localparam int IDX_W    = $clog2(N_IN);
  localparam int CFG_AW   = 4;
  localparam int THR_ADDR = N_IN;

  localparam logic [W_W-1:0] WEIGHT_RST = W_W'(1);
  localparam logic [W_W-1:0] THR_RST    = W_W'(4);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

endpackage

// File: rtl/perceptron_output_layer_seq_if.sv
// Input/output handshake and configuration bus of the output-layer perceptron.
interface perceptron_output_layer_seq_if;
    import perceptron_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [N_IN-1:0]     hidden;
    logic                cfg_we;
    logic [CFG_AW-1:0]   cfg_addr;
    logic [W_W-1:0]      cfg_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_fire;
    logic [ACC_W-1:0]    out_sum;

    modport master (
        output in_valid, hidden, cfg_we, cfg_addr, cfg_data, out_ready,
        input  in_ready, out_valid, out_fire, out_sum
    );

    modport slave (
        input  in_valid, hidden, cfg_we, cfg_addr, cfg_data, out_ready,
        output in_ready, out_valid, out_fire, out_sum
    );
endinterface

// File: rtl/perceptron_weight_rf.sv
// Weight/threshold register file: N_IN weights plus one threshold, gated write, async read.
module perceptron_weight_rf
    import perceptron_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [CFG_AW-1:0] addr,
    input  logic [W_W-1:0]    data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [W_W-1:0]    rd_weight,
    output logic [W_W-1:0]    thr
);

    logic [W_W-1:0] weights [N_IN];
    logic [W_W-1:0] thr_q;

    // NOTE: this storage is a handful of flops with defined power-up weights, so every entry is reset; a RAM-backed array would not be.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) weights[i] <= WEIGHT_RST;
            thr_q <= THR_RST;
        end else if (we) begin
            if (addr < CFG_AW'(N_IN))
                weights[addr[IDX_W-1:0]] <= data;
            else if (addr == CFG_AW'(THR_ADDR))
                thr_q <= data;
        end
    end

    assign rd_weight = weights[rd_idx];
    assign thr       = thr_q;

endmodule

// File: rtl/perceptron_output_layer_seq.sv
// Time-multiplexed output-layer perceptron: one MAC per clock over N_IN cycles.
// Optional PERCEPTRON_SKIP_ZERO_EN ends accumulation early once the remaining hidden bits are all zero.
module perceptron_output_layer_seq
    import perceptron_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    perceptron_output_layer_seq_if.slave  bus
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [N_IN-1:0]    hidden_q;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic               in_ready_q, out_valid_q, out_fire_q;
    logic [ACC_W-1:0]   out_sum_q;

    // Write arriving with an accepted vector is parked until the vector retires.
    logic               pend_valid;
    logic [CFG_AW-1:0]  pend_addr;
    logic [W_W-1:0]     pend_data;

    logic               rf_we;
    logic [CFG_AW-1:0]  rf_addr;
    logic [W_W-1:0]     rf_data;
    logic [W_W-1:0]     weight, thr;

    perceptron_weight_rf u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (rf_we),
        .addr      (rf_addr),
        .data      (rf_data),
        .rd_idx    (idx),
        .rd_weight (weight),
        .thr       (thr)
    );

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rf_we    = 1'b0;
        rf_addr  = bus.cfg_addr;
        rf_data  = bus.cfg_data;
        acc_next = acc + (hidden_q[0] ? ACC_W'(weight) : '0);
        if (state == DONE && bus.out_ready && pend_valid) begin
            rf_we   = 1'b1;
            rf_addr = pend_addr;
            rf_data = pend_data;
        end else if (state == IDLE && bus.cfg_we && !bus.in_valid) begin
            rf_we   = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            hidden_q    <= '0;
            acc         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_fire_q  <= 1'b0;
            out_sum_q   <= '0;
            pend_valid  <= 1'b0;
            pend_addr   <= '0;
            pend_data   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    hidden_q   <= bus.hidden;
                    acc        <= '0;
                    idx        <= '0;
                    in_ready_q <= 1'b0;
                    pend_valid <= bus.cfg_we;
                    pend_addr  <= bus.cfg_addr;
                    pend_data  <= bus.cfg_data;
                    state      <= ACC;
                end
                ACC: begin
`ifdef PERCEPTRON_SKIP_ZERO_EN
                    if (hidden_q == '0) begin
                        out_sum_q   <= acc;
                        out_fire_q  <= acc > ACC_W'(thr);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else
`endif
                    begin
                        // hidden_q shifts right so bit 0 always pairs with weight[idx].
                        acc      <= acc_next;
                        idx      <= idx + IDX_W'(1);
                        hidden_q <= hidden_q >> 1;
                        if (idx == IDX_LAST) begin
                            out_sum_q   <= acc_next;
                            out_fire_q  <= acc_next > ACC_W'(thr);
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    pend_valid  <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_fire  = out_fire_q;
    assign bus.out_sum   = out_sum_q;

endmodule

// File: tb/tb_perceptron_output_layer_seq.sv
// Directed self-checking bench for perceptron_output_layer_seq (either build of PERCEPTRON_SKIP_ZERO_EN).
module tb_perceptron_output_layer_seq;
    import perceptron_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    perceptron_output_layer_seq_if bus ();

    perceptron_output_layer_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef PERCEPTRON_SKIP_ZERO_EN
    localparam int LAT_ZERO = 1;
    localparam int LAT_0F   = 5;
`else
    localparam int LAT_ZERO = 8;
    localparam int LAT_0F   = 8;
`endif

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    // Returns at the negedge following the accepting edge.
    task automatic start_vector(input logic [7:0] h);
        @(negedge clk);
        bus.hidden = h; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit to);
        lat = 0;
        to  = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) to = 1'b1;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_vector(input logic [7:0] h, output logic [10:0] sum,
                              output logic fire, output int lat, output bit to);
        start_vector(h);
        wait_done(lat, to);
        sum  = bus.out_sum;
        fire = bus.out_fire;
        if (!to) consume();
    endtask

    task automatic expect_result(input string name, input logic [7:0] h,
                                 input logic [10:0] exp_sum, input logic exp_fire);
        logic [10:0] sum; logic fire; int lat; bit to;
        run_vector(h, sum, fire, lat, to);
        n_checks += 3;
        if (to) begin n_fail++; $display("FAIL %s timeout: out_valid never rose", name); end
        if (sum !== exp_sum) begin n_fail++; $display("FAIL %s sum: got %0d expected %0d", name, sum, exp_sum); end
        if (fire !== exp_fire) begin n_fail++; $display("FAIL %s fire: got %0b expected %0b", name, fire, exp_fire); end
    endtask

    task automatic expect_latency(input string name, input logic [7:0] h, input int exp_lat,
                                  input logic [10:0] exp_sum, input logic exp_fire);
        logic [10:0] sum; logic fire; int lat; bit to;
        run_vector(h, sum, fire, lat, to);
        n_checks += 3;
        if (to || lat !== exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat); end
        if (sum !== exp_sum) begin n_fail++; $display("FAIL %s sum: got %0d expected %0d", name, sum, exp_sum); end
        if (fire !== exp_fire) begin n_fail++; $display("FAIL %s fire: got %0b expected %0b", name, fire, exp_fire); end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 4;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid); end
        if (bus.out_fire !== 1'b0) begin n_fail++; $display("FAIL reset out_fire: got %b expected 0", bus.out_fire); end
        if (bus.out_sum !== 11'd0) begin n_fail++; $display("FAIL reset out_sum: got %0d expected 0", bus.out_sum); end
    endtask

    task automatic test_defaults();
        expect_latency("default_ff", 8'hFF, 8, 11'd8, 1'b1);
        expect_latency("default_0f", 8'h0F, LAT_0F, 11'd4, 1'b0);
        expect_latency("all_zero", 8'h00, LAT_ZERO, 11'd0, 1'b0);
    endtask

    task automatic test_weights();
        logic [7:0] w [8] = '{8'd2, 8'd4, 8'd2, 8'd1, 8'd5, 8'd2, 8'd2, 8'd2};
        for (int i = 0; i < 8; i++) cfg_write(4'(i), w[i]);
        cfg_write(4'd8, 8'd10);
        cfg_write(4'd12, 8'd0);
        expect_result("weights_12", 8'b0001_0010, 11'd9, 1'b0);
        expect_result("weights_13", 8'b0001_0011, 11'd11, 1'b1);
    endtask

    task automatic test_max();
        for (int i = 0; i < 9; i++) cfg_write(4'(i), 8'd255);
        expect_result("max_ff", 8'hFF, 11'd2040, 1'b1);
    endtask

    task automatic test_backpressure();
        int lat; bit to;
        start_vector(8'h03);
        wait_done(lat, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL bp timeout: out_valid never rose"); end
        bus.in_valid = 1'b1;
        bus.hidden   = 8'hFF;
        bus.cfg_we   = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_data = 8'd7;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks += 4;
            if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp out_valid c%0d: got %b expected 1", c, bus.out_valid); end
            if (bus.out_sum !== 11'd510) begin n_fail++; $display("FAIL bp out_sum c%0d: got %0d expected 510", c, bus.out_sum); end
            if (bus.out_fire !== 1'b1) begin n_fail++; $display("FAIL bp out_fire c%0d: got %b expected 1", c, bus.out_fire); end
            if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp in_ready c%0d: got %b expected 0", c, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
        consume();
        expect_result("bp_cfg_ignored", 8'h01, 11'd255, 1'b0);
    endtask

    task automatic test_cfg_in_acc();
        int lat; bit to;
        start_vector(8'h01);
        repeat (2) @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_data = 8'd9;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        wait_done(lat, to);
        n_checks += 2;
        if (to) begin n_fail++; $display("FAIL acc_cfg timeout: out_valid never rose"); end
        if (bus.out_sum !== 11'd255) begin n_fail++; $display("FAIL acc_cfg sum: got %0d expected 255", bus.out_sum); end
        if (!to) consume();
        expect_result("acc_cfg_next", 8'h01, 11'd255, 1'b0);
    endtask

    task automatic test_same_edge_cfg();
        @(negedge clk);
        bus.hidden = 8'h01; bus.in_valid = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_data = 8'd100;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.cfg_we = 1'b0;
        begin
            int lat; bit to;
            wait_done(lat, to);
            n_checks += 2;
            if (to) begin n_fail++; $display("FAIL same_edge timeout: out_valid never rose"); end
            if (bus.out_sum !== 11'd255) begin n_fail++; $display("FAIL same_edge old sum: got %0d expected 255", bus.out_sum); end
            if (!to) consume();
        end
        expect_result("same_edge_new", 8'h01, 11'd100, 1'b0);
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        start_vector(8'hFF);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks += 3;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset in_ready: got %b expected 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset out_valid: got %b expected 0", bus.out_valid); end
        if (bus.out_sum !== 11'd0) begin n_fail++; $display("FAIL mid_reset out_sum: got %0d expected 0", bus.out_sum); end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL mid_reset spurious out_valid: got %0d cycles expected 0", seen); end
        expect_result("mid_reset_weights", 8'hFF, 11'd8, 1'b1);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.hidden = '0; bus.out_ready = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        rst_n = 1'b0;
        test_reset();
        test_defaults();
        test_weights();
        test_max();
        test_backpressure();
        test_cfg_in_acc();
        test_same_edge_cfg();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
